com_sync_fifo_fwft: RTL and testbench
=====================================

# com_sync_fifo_fwft

Parametrised single-clock register-array FIFO with show-ahead (first-word-fall-through) read, selectable combinational or registered read-data path, non-power-of-two depth, registered almost-full/almost-empty thresholds, and sticky overflow/underflow flags. It is the general-purpose successor for shallow in-pipeline buffering in the common library, where the read side must see data without a read-request cycle and must not leak X when empty.

## Interface
- DW, 8: data width in bits, ≥1.
- DEPTH, 4: total capacity in entries, ≥2, any integer (not limited to powers of two).
- OUT_REG, 0: 0 = rd_data taken combinationally from the array; 1 = rd_data driven from a dedicated output register.
- AFULL_TH, DEPTH-1: wr_afull asserts when level ≥ AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1: rd_aempty asserts when level ≤ AEMPTY_TH; legal range 0..DEPTH-1.
- AW, $clog2(DEPTH+1): level width (derived, not overridden).
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- wr_en  in  1  write request.
- wr_data  in  DW  write data.
- wr_full  out  1  level == DEPTH.
- wr_afull  out  1  almost full.
- rd_en  in  1  pop request (acknowledges the currently shown word).
- rd_data  out  DW  head word; 0 when rd_empty.
- rd_empty  out  1  level == 0.
- rd_aempty  out  1  almost empty.
- water_level  out  AW  current occupancy 0..DEPTH.
- ovf  out  1  sticky: write attempted while wr_full.
- udf  out  1  sticky: read attempted while rd_empty.

## Operation
- Write accepted iff wr_en && !wr_full; pop accepted iff rd_en && !rd_empty. Full/empty are the registered values from the start of the cycle.
- Full with wr_en && rd_en: pop accepted, write dropped, ovf set. Empty with both: write accepted, pop dropped, udf set.
- Level: +1 on write only, −1 on pop only, unchanged on both or neither.
- OUT_REG=0: array of DEPTH entries; rd_data = array[rd_ptr] masked to 0 when empty.
- OUT_REG=1: array of DEPTH-1 entries plus output register (valid bit = !rd_empty). Write into empty FIFO, or a write coinciding with a pop while the array is empty, bypasses straight into the output register. A pop while the array is non-empty refills the output register from the array head in the same edge. Output register data is not cleared on pop; the zero mask applies.
- Pointers wrap explicitly from last index to 0 (no modulo-2ᴺ reliance).
- clear: pointers, level, output-register valid, ovf, udf to reset values at next edge; clear dominates wr_en/rd_en in the same cycle (neither accepted, no flags set). Array contents are not cleared.
- ovf/udf remain set until clear or reset.

## Timing
- Reset values: wr_full 0, wr_afull 0, rd_empty 1, rd_aempty 1, water_level 0, ovf 0, udf 0, rd_data 0.
- All status outputs (full, empty, afull, aempty, level, ovf, udf) are registers updated at the edge that accepts the event; no combinational path from wr_en/rd_en to any status output.
- Write-to-read latency: 1 edge in both modes (word written at edge N is on rd_data with rd_empty=0 after edge N).
- Pop-to-next-word: next word visible after the popping edge in both modes.
- OUT_REG=1: rd_data has no combinational path from array read mux; OUT_REG=0: rd_data depends combinationally only on registered state.
- Reset asserted mid-operation: all state returns to reset values asynchronously; first accepted write after deassertion behaves as into an empty FIFO.

## Structure
- Package com_fifo_pkg: localparams for OUT_REG encodings (FIFO_OUT_COMB=0, FIFO_OUT_REG=1) and a level-width function shared with other common FIFOs.
- Sub-module com_fifo_ptr_ctrl: wrapping pointers, level counter, full/empty/afull/aempty/ovf/udf registers, parametrised on entry count; top instantiates it with DEPTH or DEPTH-1 array entries and adds the output-register stage.
- Elaboration-time checks on DEPTH, AFULL_TH, AEMPTY_TH ranges.

## Test plan
- DW=8, DEPTH=5, both modes: write 0x11..0x15 back-to-back -> wr_full=1 after 5th edge, level=5, wr_afull=1 from level 4; pop 5 -> rd_data 0x11..0x15 in order, then rd_empty=1, rd_data=0.
- Full, wr_en=rd_en=1 with 0xAA -> 0x11 popped, 0xAA dropped, ovf=1, level stays 4 after edge.
- Empty, wr_en=rd_en=1 with 0x5C -> udf=1, level=1, rd_data=0x5C next cycle.
- Continuous simultaneous write/pop for 23 cycles at level 2 (DEPTH=5) -> pointer wrap several times, level constant 2, data order preserved.
- clear asserted with wr_en=1 at level 3, ovf=1 -> level=0, rd_empty=1, ovf=0, write not accepted.
- rst_n pulsed low mid-stream at level 3 -> all outputs at reset values immediately; after release a write of 0x7E appears at rd_data after one edge.

Source files
------------

// File: rtl/com_fifo_pkg.sv
// Shared constants and sizing helpers for the common-library FIFOs.
package com_fifo_pkg;

  localparam int FIFO_OUT_COMB = 0;
  localparam int FIFO_OUT_REG  = 1;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int fifo_level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_ptr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/com_sync_fifo_fwft_if.sv
// Write/read handshake and status bundle for com_sync_fifo_fwft.
interface com_sync_fifo_fwft_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  import com_fifo_pkg::*;

  localparam int AW = fifo_level_width(DEPTH);

  logic          clear;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_full;
  logic          wr_afull;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          rd_aempty;
  logic [AW-1:0] water_level;
  logic          ovf;
  logic          udf;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty, water_level, ovf, udf
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output wr_full, wr_afull, rd_data, rd_empty, rd_aempty, water_level, ovf, udf
  );

endinterface

// File: rtl/com_fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag control for a register-array FIFO.
// HEAD_REG=1 adds one slot held outside the array (output register) to the capacity.
module com_fifo_ptr_ctrl
  import com_fifo_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int HEAD_REG  = 0,
  parameter int AFULL_TH  = ENTRIES + HEAD_REG - 1,
  parameter int AEMPTY_TH = 1,
  localparam int CAP      = ENTRIES + HEAD_REG,
  localparam int AW       = fifo_level_width(CAP),
  localparam int PW       = fifo_ptr_width(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          arr_push,
  output logic          arr_pop,
  output logic          bypass,
  output logic          full,
  output logic          afull,
  output logic          empty,
  output logic          aempty,
  output logic [AW-1:0] level,
  output logic          ovf,
  output logic          udf
);

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] level_nxt;

  // With a head register the array only holds words behind the shown one,
  // so a write lands in the head whenever the array would otherwise be empty.
  always_comb begin
    wr_acc    = wr_en && !full && !clear;
    rd_acc    = rd_en && !empty && !clear;
    bypass    = 1'b0;
    arr_push  = wr_acc;
    arr_pop   = rd_acc;
    level_nxt = level;
    if (HEAD_REG != 0) begin
      bypass   = wr_acc && (empty || (rd_acc && (level == AW'(1))));
      arr_push = wr_acc && !bypass;
      arr_pop  = rd_acc && (level > AW'(1));
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + AW'(1);
      2'b01:   level_nxt = level - AW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      afull  <= 1'b0;
      empty  <= 1'b1;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      afull  <= 1'b0;
      empty  <= 1'b1;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (arr_push) begin
        wr_ptr <= (wr_ptr == PW'(ENTRIES - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (arr_pop) begin
        rd_ptr <= (rd_ptr == PW'(ENTRIES - 1)) ? '0 : rd_ptr + PW'(1);
      end
      level  <= level_nxt;
      full   <= (level_nxt == AW'(CAP));
      afull  <= (level_nxt >= AW'(AFULL_TH));
      empty  <= (level_nxt == '0);
      aempty <= (level_nxt <= AW'(AEMPTY_TH));
      ovf    <= ovf | (wr_en && full);
      udf    <= udf | (rd_en && empty);
    end
  end

endmodule

// File: rtl/com_sync_fifo_fwft.sv
// Single-clock show-ahead FIFO with any depth >= 2, optional registered read data,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module com_sync_fifo_fwft
  import com_fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int OUT_REG   = FIFO_OUT_COMB,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  com_sync_fifo_fwft_if.slave bus
);

  localparam int HEAD_REG = (OUT_REG == FIFO_OUT_REG) ? 1 : 0;
  localparam int ENTRIES  = DEPTH - HEAD_REG;
  localparam int PW       = fifo_ptr_width(ENTRIES);

  if (DW < 1) begin : g_bad_dw
    $error("com_sync_fifo_fwft: DW must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("com_sync_fifo_fwft: DEPTH must be >= 2");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
    $error("com_sync_fifo_fwft: AFULL_TH must be in 1..DEPTH");
  end
  if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
    $error("com_sync_fifo_fwft: AEMPTY_TH must be in 0..DEPTH-1");
  end
  if ((OUT_REG != FIFO_OUT_COMB) && (OUT_REG != FIFO_OUT_REG)) begin : g_bad_outreg
    $error("com_sync_fifo_fwft: OUT_REG must be 0 or 1");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          arr_push;
  logic          arr_pop;
  logic          bypass;
  logic [DW-1:0] mem [ENTRIES];

  com_fifo_ptr_ctrl #(
    .ENTRIES   (ENTRIES),
    .HEAD_REG  (HEAD_REG),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.clear),
    .wr_en    (bus.wr_en),
    .rd_en    (bus.rd_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .arr_push (arr_push),
    .arr_pop  (arr_pop),
    .bypass   (bypass),
    .full     (bus.wr_full),
    .afull    (bus.wr_afull),
    .empty    (bus.rd_empty),
    .aempty   (bus.rd_aempty),
    .level    (bus.water_level),
    .ovf      (bus.ovf),
    .udf      (bus.udf)
  );

  // Storage is deliberately not reset; stale words are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (arr_push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  if (HEAD_REG != 0) begin : g_out_reg
    logic [DW-1:0] out_q;

    // Head register takes a write directly when nothing is queued behind it,
    // otherwise refills from the array head on every accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else if (bypass) begin
        out_q <= bus.wr_data;
      end else if (arr_pop) begin
        out_q <= mem[rd_ptr];
      end
    end

    assign bus.rd_data = bus.rd_empty ? '0 : out_q;
  end else begin : g_out_comb
    wire unused_ctrl = bypass | arr_pop;

    assign bus.rd_data = bus.rd_empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_com_sync_fifo_fwft.sv
// Directed check of com_sync_fifo_fwft, DEPTH=5, run on combinational and
// registered read-data variants side by side with identical stimulus.
module tb_com_sync_fifo_fwft;
  import com_fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;

  int vectors;
  int miscompares;

  com_sync_fifo_fwft_if #(.DW(8), .DEPTH(5)) bus_c ();
  com_sync_fifo_fwft_if #(.DW(8), .DEPTH(5)) bus_r ();

  assign bus_c.clear   = clear;
  assign bus_c.wr_en   = wr_en;
  assign bus_c.rd_en   = rd_en;
  assign bus_c.wr_data = wr_data;
  assign bus_r.clear   = clear;
  assign bus_r.wr_en   = wr_en;
  assign bus_r.rd_en   = rd_en;
  assign bus_r.wr_data = wr_data;

  com_sync_fifo_fwft #(.DW(8), .DEPTH(5), .OUT_REG(FIFO_OUT_COMB)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  com_sync_fifo_fwft #(.DW(8), .DEPTH(5), .OUT_REG(FIFO_OUT_REG)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    clear   = c;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  // Packed as {full, afull, empty, aempty, ovf, udf, level[2:0], data[7:0]}.
  task automatic check_one(input string tag, input string mode, input logic [16:0] obs, input logic [16:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s/%s: got flags=%b lvl=%0d data=%h, expected flags=%b lvl=%0d data=%h",
             tag, mode, obs[16:11], obs[10:8], obs[7:0], exp[16:11], exp[10:8], exp[7:0]);
    end
  endtask

  task automatic check_output(input string tag, input int lvl, input logic [7:0] data, input logic [5:0] flags);
    logic [16:0] exp;
    exp = {flags, 3'(lvl), data};
    check_one(tag, "comb", {bus_c.wr_full, bus_c.wr_afull, bus_c.rd_empty, bus_c.rd_aempty,
                            bus_c.ovf, bus_c.udf, bus_c.water_level, bus_c.rd_data}, exp);
    check_one(tag, "oreg", {bus_r.wr_full, bus_r.wr_afull, bus_r.rd_empty, bus_r.rd_aempty,
                            bus_r.ovf, bus_r.udf, bus_r.water_level, bus_r.rd_data}, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_data     = 8'h00;
    #12;
    check_output("reset", 0, 8'h00, 6'b001100);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill 0x11..0x15 then drain");
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
      check_output("fill", i, 8'h11, {(i == 5), (i >= 4), 1'b0, (i <= 1), 2'b00});
    end
    for (int j = 1; j <= 5; j++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
      check_output("drain", 5 - j, (j < 5) ? 8'h11 + 8'(j) : 8'h00,
                   {1'b0, ((5 - j) >= 4), ((5 - j) == 0), ((5 - j) <= 1), 2'b00});
    end

    $display("[TB] write+pop while full");
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
    check_output("refill", 5, 8'h11, 6'b110000);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'hAA);
    check_output("full_wr_rd", 4, 8'h12, 6'b010010);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_output("ovf_drain3", 3, 8'h13, 6'b000010);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_output("ovf_drain2", 2, 8'h14, 6'b000010);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_output("ovf_drain1", 1, 8'h15, 6'b000110);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_output("ovf_drain0", 0, 8'h00, 6'b001110);

    $display("[TB] write+pop while empty");
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h5C);
    check_output("empty_wr_rd", 1, 8'h5C, 6'b000111);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h21);
    check_output("level2", 2, 8'h5C, 6'b000011);

    $display("[TB] 23 cycles of streaming at level 2");
    for (int k = 0; k < 23; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 8'h30 + 8'(k));
      check_output("stream", 2, (k == 0) ? 8'h21 : 8'h30 + 8'(k - 1), 6'b000011);
    end

    $display("[TB] clear beats write");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h47);
    check_output("level3", 3, 8'h45, 6'b000011);
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h99);
    check_output("clear", 0, 8'h00, 6'b001100);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    check_output("post_clear", 0, 8'h00, 6'b001100);

    $display("[TB] async reset mid-stream");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h61);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h62);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h63);
    check_output("pre_reset", 3, 8'h61, 6'b000000);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("mid_reset", 0, 8'h00, 6'b001100);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h7E);
    check_output("after_reset", 1, 8'h7E, 6'b000100);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_output("pop_last", 0, 8'h00, 6'b001100);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_output("pop_empty", 0, 8'h00, 6'b001101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
